// File: rtl/coh_pkg.sv
// Shared types and constants for the MSI coherence bus controller.
package coh_pkg;

    localparam int unsigned TAG_W = 17;
    localparam int unsigned IDX_W = 10;
    localparam int unsigned OFF_W = 5;

    typedef enum logic [1:0] {
        BUS_RD   = 2'b00,
        BUS_RDX  = 2'b01,
        BUS_UPGR = 2'b10,
        BUS_WB   = 2'b11
    } bus_op_e;

    typedef enum logic [1:0] {
        INV = 2'b00,
        SHD = 2'b01,
        MOD = 2'b11
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SNOOP   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_MEMRD   = 3'd3,
        ST_MEMWAIT = 3'd4,
        ST_WB      = 3'd5,
        ST_RESP    = 3'd6
    } ctrl_state_e;

    // Index width for an N-entry vector; never zero so single-core builds still have a port.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coh_rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr_i and wraps.
module coh_rr_arbiter
    import coh_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = coh_pkg::idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_c_o,
    output logic [IW-1:0] gnt_idx_c_o,
    output logic          gnt_vld_c_o
);

    int unsigned pos;

    always_comb begin
        gnt_c_o     = '0;
        gnt_idx_c_o = '0;
        gnt_vld_c_o = 1'b0;
        pos         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!gnt_vld_c_o && req_i[IW'(pos)]) begin
                gnt_c_o[IW'(pos)] = 1'b1;
                gnt_idx_c_o       = IW'(pos);
                gnt_vld_c_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/msi_bus_controller.sv
// MSI coherence bus sequencer: arbitration, snoop broadcast, owner flush and memory fill.
// Define COH_PERF_CNT_EN to add transaction / intervention / writeback counters.
module msi_bus_controller
    import coh_pkg::*;
#(
    parameter int unsigned NCORE  = 2,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned LINE_W = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NCORE-1:0]          req_valid,
    input  logic [NCORE*2-1:0]        req_op,
    input  logic [NCORE*ADDR_W-1:0]   req_addr,
    input  logic [NCORE*LINE_W-1:0]   req_wdata,
    output logic [NCORE-1:0]          resp_valid,
    output logic [LINE_W-1:0]         resp_data,
    output logic                      snoop_valid,
    output logic [1:0]                snoop_op,
    output logic [ADDR_W-OFF_W-1:0]   snoop_addr,
    output logic [NCORE-1:0]          snoop_src,
    input  logic [NCORE-1:0]          snoop_ack,
    input  logic [NCORE-1:0]          snoop_dirty,
    input  logic [NCORE*LINE_W-1:0]   snoop_data,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-OFF_W-1:0]   mem_addr,
    output logic [LINE_W-1:0]         mem_wdata,
    input  logic                      mem_ready,
    input  logic                      mem_rvalid,
    input  logic [LINE_W-1:0]         mem_rdata
`ifdef COH_PERF_CNT_EN
   ,output logic [31:0]               perf_txn_o,
    output logic [31:0]               perf_intv_o,
    output logic [31:0]               perf_wb_o
`endif
);

    localparam int unsigned IW   = coh_pkg::idx_w(NCORE);
    localparam int unsigned LA_W = ADDR_W - OFF_W;

    ctrl_state_e       state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [NCORE-1:0]  src_q, src_d;
    bus_op_e           op_q, op_d;
    logic [LA_W-1:0]   addr_q, addr_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [NCORE-1:0]  ack_q, ack_d;
    logic              own_vld_q, own_vld_d;
    logic [IW-1:0]     own_idx_q, own_idx_d;
    logic              snoop_valid_q, snoop_valid_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [NCORE-1:0]  resp_valid_q, resp_valid_d;

    logic [NCORE-1:0]  gnt;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    logic [NCORE-1:0]  new_ack;
    logic              unused_ok;

    // Offset bits of the request address carry no meaning on a line-granular bus.
    assign unused_ok = ^req_addr;

    coh_rr_arbiter #(
        .N (NCORE)
    ) u_arb (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .gnt_c_o     (gnt),
        .gnt_idx_c_o (gnt_idx),
        .gnt_vld_c_o (gnt_vld)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            idx_q         <= '0;
            src_q         <= '0;
            op_q          <= BUS_RD;
            addr_q        <= '0;
            line_q        <= '0;
            ack_q         <= '0;
            own_vld_q     <= 1'b0;
            own_idx_q     <= '0;
            snoop_valid_q <= 1'b0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            resp_valid_q  <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            idx_q         <= idx_d;
            src_q         <= src_d;
            op_q          <= op_d;
            addr_q        <= addr_d;
            line_q        <= line_d;
            ack_q         <= ack_d;
            own_vld_q     <= own_vld_d;
            own_idx_q     <= own_idx_d;
            snoop_valid_q <= snoop_valid_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            resp_valid_q  <= resp_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        src_d         = src_q;
        op_d          = op_q;
        addr_d        = addr_q;
        line_d        = line_q;
        ack_d         = ack_q;
        own_vld_d     = own_vld_q;
        own_idx_d     = own_idx_q;
        new_ack       = '0;
        snoop_valid_d = 1'b0;
        mem_req_d     = 1'b0;
        mem_we_d      = 1'b0;
        resp_valid_d  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    idx_d     = gnt_idx;
                    src_d     = gnt;
                    ack_d     = '0;
                    own_vld_d = 1'b0;
                    own_idx_d = '0;
                    for (int i = 0; i < int'(NCORE); i++) begin
                        if (gnt[i]) begin
                            op_d   = bus_op_e'(req_op[2*i +: 2]);
                            addr_d = req_addr[i*ADDR_W + OFF_W +: LA_W];
                            line_d = req_wdata[i*LINE_W +: LINE_W];
                        end
                    end
                    state_d = (op_d == BUS_WB) ? ST_WB : ST_SNOOP;
                end
            end
            ST_SNOOP: begin
                new_ack = snoop_ack & ~src_q;
                ack_d   = ack_q | new_ack;
                // Lowest-index dirty responder owns the line, even across cycles.
                for (int j = 0; j < int'(NCORE); j++) begin
                    if (new_ack[j] && snoop_dirty[j] &&
                        (!own_vld_d || (IW'(j) < own_idx_d))) begin
                        own_vld_d = 1'b1;
                        own_idx_d = IW'(j);
                        line_d    = snoop_data[j*LINE_W +: LINE_W];
                    end
                end
                if (&(ack_d | src_q)) begin
                    if (own_vld_d) begin
                        state_d = ST_FLUSH;
                    end else if (op_q == BUS_UPGR) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_MEMRD;
                    end
                end
            end
            ST_FLUSH: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_MEMRD: begin
                if (mem_ready) begin
                    state_d = ST_MEMWAIT;
                end
            end
            ST_MEMWAIT: begin
                if (mem_rvalid) begin
                    line_d  = mem_rdata;
                    state_d = ST_RESP;
                end
            end
            ST_WB: begin
                if (mem_ready) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (32'(idx_q) == NCORE - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = idx_q + IW'(1);
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        snoop_valid_d = (state_d == ST_SNOOP);
        mem_req_d     = (state_d == ST_FLUSH) || (state_d == ST_MEMRD) || (state_d == ST_WB);
        mem_we_d      = (state_d == ST_FLUSH) || (state_d == ST_WB);
        resp_valid_d  = (state_d == ST_RESP) ? src_d : '0;
    end

    assign resp_valid  = resp_valid_q;
    assign resp_data   = line_q;
    assign snoop_valid = snoop_valid_q;
    assign snoop_op    = 2'(op_q);
    assign snoop_addr  = addr_q;
    assign snoop_src   = src_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = line_q;

`ifdef COH_PERF_CNT_EN
    logic [31:0] perf_txn_q, perf_intv_q, perf_wb_q;

    // Counters bump in the RESP cycle; own_vld_q marks a transaction served by a flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_txn_q  <= '0;
            perf_intv_q <= '0;
            perf_wb_q   <= '0;
        end else if (state_q == ST_RESP) begin
            perf_txn_q <= perf_txn_q + 32'd1;
            if (own_vld_q) begin
                perf_intv_q <= perf_intv_q + 32'd1;
            end
            if (op_q == BUS_WB) begin
                perf_wb_q <= perf_wb_q + 32'd1;
            end
        end
    end

    assign perf_txn_o  = perf_txn_q;
    assign perf_intv_o = perf_intv_q;
    assign perf_wb_o   = perf_wb_q;
`endif

endmodule

// File: tb/tb_msi_bus_controller.sv
// Directed bench for msi_bus_controller: cache/memory responders plus a response scoreboard.
module tb_msi_bus_controller;
    import coh_pkg::*;

    localparam int unsigned NC  = 2;
    localparam int unsigned AW  = 32;
    localparam int unsigned LW  = 256;
    localparam int unsigned LAW = AW - 5;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     req_valid;
    logic [NC*2-1:0]   req_op;
    logic [NC*AW-1:0]  req_addr;
    logic [NC*LW-1:0]  req_wdata;
    logic [NC-1:0]     resp_valid;
    logic [LW-1:0]     resp_data;
    logic              snoop_valid;
    logic [1:0]        snoop_op;
    logic [LAW-1:0]    snoop_addr;
    logic [NC-1:0]     snoop_src;
    logic [NC-1:0]     snoop_ack;
    logic [NC-1:0]     snoop_dirty;
    logic [NC*LW-1:0]  snoop_data;
    logic              mem_req;
    logic              mem_we;
    logic [LAW-1:0]    mem_addr;
    logic [LW-1:0]     mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [LW-1:0]     mem_rdata;
`ifdef COH_PERF_CNT_EN
    logic [31:0]       perf_txn, perf_intv, perf_wb;
`endif

    msi_bus_controller #(.NCORE(NC), .ADDR_W(AW), .LINE_W(LW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .snoop_valid (snoop_valid),
        .snoop_op    (snoop_op),
        .snoop_addr  (snoop_addr),
        .snoop_src   (snoop_src),
        .snoop_ack   (snoop_ack),
        .snoop_dirty (snoop_dirty),
        .snoop_data  (snoop_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
`ifdef COH_PERF_CNT_EN
       ,.perf_txn_o  (perf_txn),
        .perf_intv_o (perf_intv),
        .perf_wb_o   (perf_wb)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          core;
        logic [LW-1:0] data;
        bit          chk_data;
    } exp_t;

    exp_t sb[$];

    int            total  = 0;
    int            passed = 0;

    int            ack_dly [NC];
    bit            dirty   [NC];
    logic [LW-1:0] sdat    [NC];
    int            rdy_dly;
    int            rv_dly;
    logic [LW-1:0] mem_line;
    bit            cont;

    int            snp_cyc, memreq_cyc, wr_cnt, rd_cnt, resp_cnt, last_lat, src_err;
    logic [LAW-1:0] wr_addr, rd_addr, snp_addr;
    logic [LW-1:0] wr_data;

    logic [LW-1:0] line_a, line_b, line_c, line_d;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clr;
        for (int j = 0; j < int'(NC); j++) begin
            ack_dly[j] = 0;
            dirty[j]   = 1'b0;
            sdat[j]    = '0;
        end
        rdy_dly = 0; rv_dly = 1; mem_line = '0; cont = 1'b0;
        snp_cyc = 0; memreq_cyc = 0; wr_cnt = 0; rd_cnt = 0; resp_cnt = 0;
        last_lat = 0; src_err = 0;
        wr_addr = '0; rd_addr = '0; snp_addr = '0; wr_data = '0;
    endtask

    task automatic set_req(input int c, input bus_op_e op, input logic [AW-1:0] a,
                           input logic [LW-1:0] wd);
        req_valid[c]          = 1'b1;
        req_op[c*2 +: 2]      = 2'(op);
        req_addr[c*AW +: AW]  = a;
        req_wdata[c*LW +: LW] = wd;
    endtask

    task automatic push(input int c, input logic [LW-1:0] d, input bit cd);
        exp_t e;
        e.core = c; e.data = d; e.chk_data = cd;
        sb.push_back(e);
    endtask

    // Acts as the caches and the memory each cycle; pops the scoreboard on every resp pulse.
    task automatic service(input int n, input int max_cyc, input bit tmo_ok);
        int k = 0, scnt = 0, mcnt = 0, rvcd = 0, got = 0;
        exp_t e;
        logic [NC-1:0] exp_src;
        while (got < n && k < max_cyc) begin
            @(negedge clk);
            k++;
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            if (rvcd > 0) begin
                rvcd--;
                if (rvcd == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_line;
                end
            end
            if (snoop_valid) begin
                scnt++;
                snp_cyc++;
                if (scnt == 1) snp_addr = snoop_addr;
                exp_src = (sb.size() > 0) ? NC'(1) << sb[0].core : '0;
                if (snoop_src !== exp_src) src_err++;
                for (int j = 0; j < int'(NC); j++) begin
                    snoop_ack[j]           = !snoop_src[j] && (scnt - 1 >= ack_dly[j]);
                    snoop_dirty[j]         = snoop_ack[j] && dirty[j];
                    snoop_data[j*LW +: LW] = sdat[j];
                end
            end else begin
                scnt        = 0;
                snoop_ack   = '0;
                snoop_dirty = '0;
            end
            if (mem_req) begin
                memreq_cyc++;
                mcnt++;
                if (mcnt - 1 >= rdy_dly) begin
                    mem_ready = 1'b1;
                    mcnt      = 0;
                    if (mem_we) begin
                        wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata;
                    end else begin
                        rd_cnt++; rd_addr = mem_addr; rvcd = rv_dly;
                    end
                end
            end else begin
                mcnt = 0;
            end
            if (resp_valid != '0) begin
                got++;
                resp_cnt++;
                last_lat = k;
                if (sb.size() == 0) begin
                    chk("resp_unexpected", LW'(resp_valid), '0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_core", LW'(resp_valid), LW'(NC'(1) << e.core));
                    if (e.chk_data) chk("resp_data", resp_data, e.data);
                    if (!cont) req_valid[e.core] = 1'b0;
                end
            end
        end
        if (!tmo_ok) chk("resp_count_timeout", LW'(got), LW'(n));
        mem_ready = 1'b0; mem_rvalid = 1'b0; snoop_ack = '0; snoop_dirty = '0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = '0; req_op = '0; req_addr = '0; req_wdata = '0;
        snoop_ack = '0; snoop_dirty = '0; snoop_data = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        line_a = {8{32'hA5A5_0001}};
        line_b = {8{32'hB0B0_0002}};
        line_c = {8{32'hC3C3_0003}};
        line_d = {8{32'hD7D7_0004}};
        clr();

        repeat (3) @(negedge clk);
        chk("rst_resp_valid", LW'(resp_valid), '0);
        chk("rst_snoop_valid", LW'(snoop_valid), '0);
        chk("rst_snoop_src", LW'(snoop_src), '0);
        chk("rst_mem_req", LW'(mem_req), '0);
        chk("rst_mem_we", LW'(mem_we), '0);
        chk("rst_resp_data", resp_data, '0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Core0 read served from memory.
        clr(); mem_line = line_a;
        set_req(0, BUS_RD, 32'h0000_3040, '0);
        push(0, line_a, 1'b1);
        service(1, 40, 1'b0);
        chk("t1_snoop_addr", LW'(snp_addr), LW'(27'h182));
        chk("t1_rd_addr", LW'(rd_addr), LW'(27'h182));
        chk("t1_rd_cnt", LW'(rd_cnt), LW'(1));
        chk("t1_wr_cnt", LW'(wr_cnt), '0);
        chk("t1_latency", LW'(last_lat), LW'(4));
        repeat (2) @(negedge clk);

        // Core1 read-exclusive with core0 holding the line dirty.
        clr(); dirty[0] = 1'b1; sdat[0] = line_b; mem_line = line_a;
        set_req(1, BUS_RDX, 32'h0000_3040, '0);
        push(1, line_b, 1'b1);
        service(1, 40, 1'b0);
        chk("t2_wr_cnt", LW'(wr_cnt), LW'(1));
        chk("t2_wr_addr", LW'(wr_addr), LW'(27'h182));
        chk("t2_wr_data", wr_data, line_b);
        chk("t2_rd_cnt", LW'(rd_cnt), '0);
        repeat (2) @(negedge clk);

        // Both cores request continuously: strict alternation from core0.
        clr(); cont = 1'b1; mem_line = line_c;
        set_req(0, BUS_RD, 32'h0000_1000, '0);
        set_req(1, BUS_RD, 32'h0000_2000, '0);
        for (int t = 0; t < 6; t++) push(t % 2, line_c, 1'b1);
        service(6, 200, 1'b0);
        req_valid = '0;
        chk("t4_resp_cnt", LW'(resp_cnt), LW'(6));
        chk("t4_snoop_src_err", LW'(src_err), '0);
        chk("t4_snoop_cyc", LW'(snp_cyc), LW'(6));
        chk("t4_rd_cnt", LW'(rd_cnt), LW'(6));
        repeat (2) @(negedge clk);

        // Core0 upgrade, core1 acks clean on the third snoop cycle.
        clr(); ack_dly[1] = 2;
        set_req(0, BUS_UPGR, 32'h0000_3040, '0);
        push(0, '0, 1'b0);
        service(1, 40, 1'b0);
        chk("t3_snoop_cyc", LW'(snp_cyc), LW'(3));
        chk("t3_memreq_cyc", LW'(memreq_cyc), '0);
        chk("t3_latency", LW'(last_lat), LW'(4));
        repeat (2) @(negedge clk);

        // Core1 upgrade with immediate ack: two-cycle turnaround.
        clr();
        set_req(1, BUS_UPGR, 32'h0000_5040, '0);
        push(1, '0, 1'b0);
        service(1, 40, 1'b0);
        chk("t3b_latency", LW'(last_lat), LW'(2));
        chk("t3b_memreq_cyc", LW'(memreq_cyc), '0);
        repeat (2) @(negedge clk);

        // Core1 writeback: memory write only, no snoop.
        clr();
        set_req(1, BUS_WB, 32'h0000_7FE0, line_c);
        push(1, '0, 1'b0);
        service(1, 40, 1'b0);
        chk("t5_snoop_cyc", LW'(snp_cyc), '0);
        chk("t5_wr_cnt", LW'(wr_cnt), LW'(1));
        chk("t5_wr_addr", LW'(wr_addr), LW'(27'h3FF));
        chk("t5_wr_data", wr_data, line_c);
        chk("t5_rd_cnt", LW'(rd_cnt), '0);
        repeat (2) @(negedge clk);

        // Reset while the controller waits on a memory read.
        clr(); rdy_dly = 1000;
        set_req(0, BUS_RD, 32'h0000_3040, '0);
        service(1, 5, 1'b1);
        chk("t6_resp_before_rst", LW'(resp_cnt), '0);
        chk("t6_mem_req_before_rst", LW'(mem_req), LW'(1));
        rst = 1'b0;
        #1;
        chk("t6_mem_req_in_rst", LW'(mem_req), '0);
        chk("t6_resp_in_rst", LW'(resp_valid), '0);
        chk("t6_snoop_in_rst", LW'(snoop_valid), '0);
        req_valid = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        service(1, 4, 1'b1);
        chk("t6_no_resp_after_rst", LW'(resp_cnt), '0);

        clr(); mem_line = line_d;
        set_req(0, BUS_RD, 32'h0000_3040, '0);
        push(0, line_d, 1'b1);
        service(1, 40, 1'b0);
        chk("t6_post_rd_addr", LW'(rd_addr), LW'(27'h182));
        chk("t6_post_latency", LW'(last_lat), LW'(4));
        chk("sb_empty", LW'(sb.size()), '0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
